u_exu_pipe: RTL

U_EXU_PIPE -- requirements
Module: u_exu_pipe

---
 rtl/u_exu_pipe.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/u_exu_pipe.sv
// -----------------------------------------------------------------------------
// u_exu_pipe
// Execution unit for the RISC-V U-type instructions (LUI / AUIPC). An accepted
// instruction travels through STAGES register stages. The last of those stages
// is the result queue itself, so a result leaves exactly STAGES cycles after it
// is accepted when the queue is empty. Admission is credit based: a single
// occupancy counter covers everything in flight plus everything queued. in_rdy
// therefore never depends on out_rdy or in_vld in the same cycle.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_vld/rdy   input handshake; in_rdy also drops during flush
//   in_op        0 = LUI, 1 = AUIPC
//   in_pc        PC of the offered instruction (PC_W bits, zero-extended)
//   in_rd        destination register index
//   in_imm       raw U-immediate bits [31:12]
//   flush        discards every in-flight and queued result
//   out_vld/rdy  output handshake on the queue head
//   out_rd       GPR write address
//   out_wdata    GPR write data (XLEN bits)
//   out_wen      GPR write enable; 0 for x0, but the result is still delivered
//   retired_cnt  wrapping count of consumed results; flush leaves it alone
// -----------------------------------------------------------------------------
module u_exu_pipe #(
    parameter int XLEN   = 32,
    parameter int PC_W   = 32,
    parameter int STAGES = 1,
    parameter int DEPTH  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic            in_op,
    input  logic [PC_W-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic [19:0]     in_imm,
    input  logic            flush,
    output logic            out_vld,
    input  logic            out_rdy,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_wdata,
    output logic            out_wen,
    output logic [15:0]     retired_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    // {imm, 12'b0} sign-extended from bit 31 up to XLEN.
    function automatic logic signed [XLEN-1:0] ext_uimm(input logic [19:0] imm);
        logic signed [XLEN-1:0] r;
        r = {XLEN{imm[19]}};
        r[31:0] = {imm, 12'h000};
        return r;
    endfunction

    logic                   acc;
    logic                   pop;
    logic                   up_q;
    logic [OW-1:0]          occ_q, occ_d;
    logic [OW-1:0]          cnt_q, cnt_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [15:0]            ret_q, ret_d;

    logic [XLEN-1:0]        pc_ext;
    logic signed [XLEN-1:0] imm_ext;
    logic [XLEN-1:0]        res_d;
    logic                   wen_d;

    logic                   q_wr_vld;
    logic [4:0]             q_wr_rd;
    logic                   q_wr_wen;
    logic [XLEN-1:0]        q_wr_data;

    logic [4:0]             q_rd_mem   [DEPTH];
    logic                   q_wen_mem  [DEPTH];
    logic [XLEN-1:0]        q_data_mem [DEPTH];

    // up_q holds in_rdy low during reset and until the first edge after it.
    assign in_rdy = up_q && !flush && (occ_q < DEPTH_C);
    assign acc    = in_vld && in_rdy;
    assign out_vld = (cnt_q != '0);
    assign pop    = out_vld && out_rdy;

    // ---- stage p0: result computation (combinational, at accept) ----
    always_comb begin
        pc_ext = '0;
        pc_ext[PC_W-1:0] = in_pc;
        imm_ext = ext_uimm(in_imm);
        res_d = in_op ? (pc_ext + $unsigned(imm_ext)) : $unsigned(imm_ext);
        wen_d = (in_rd != 5'd0);
    end

    generate
        if (STAGES == 1) begin : g_direct
            assign q_wr_vld  = acc;
            assign q_wr_rd   = in_rd;
            assign q_wr_wen  = wen_d;
            assign q_wr_data = res_d;
        end else begin : g_pipe
            localparam int N = STAGES - 1;
            logic            vld_pn_q  [N];
            logic [4:0]      rd_pn_q   [N];
            logic            wen_pn_q  [N];
            logic [XLEN-1:0] data_pn_q [N];

            // ---- stages p1..p(STAGES-1): shift registers ahead of the queue ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < N; i++) vld_pn_q[i] <= 1'b0;
                end else if (flush) begin
                    for (int i = 0; i < N; i++) vld_pn_q[i] <= 1'b0;
                end else begin
                    vld_pn_q[0] <= acc;
                    for (int i = 1; i < N; i++) vld_pn_q[i] <= vld_pn_q[i-1];
                end
            end

            // Data registers carry no reset; their valid bits qualify them.
            always_ff @(posedge clk) begin
                rd_pn_q[0]   <= in_rd;
                wen_pn_q[0]  <= wen_d;
                data_pn_q[0] <= res_d;
                for (int i = 1; i < N; i++) begin
                    rd_pn_q[i]   <= rd_pn_q[i-1];
                    wen_pn_q[i]  <= wen_pn_q[i-1];
                    data_pn_q[i] <= data_pn_q[i-1];
                end
            end

            assign q_wr_vld  = vld_pn_q[N-1];
            assign q_wr_rd   = rd_pn_q[N-1];
            assign q_wr_wen  = wen_pn_q[N-1];
            assign q_wr_data = data_pn_q[N-1];
        end
    endgenerate

    // ---- final stage: result queue ----
    // Credits guarantee the queue is never written while full, so the head
    // slot is never overwritten and out_* stay stable while stalled.
    always_ff @(posedge clk) begin
        if (q_wr_vld && !flush) begin
            q_rd_mem[wr_ptr_q]   <= q_wr_rd;
            q_wen_mem[wr_ptr_q]  <= q_wr_wen;
            q_data_mem[wr_ptr_q] <= q_wr_data;
        end
    end

    assign out_rd      = q_rd_mem[rd_ptr_q];
    assign out_wen     = q_wen_mem[rd_ptr_q];
    assign out_wdata   = q_data_mem[rd_ptr_q];
    assign retired_cnt = ret_q;

    // A pop in the flush cycle still counts as retired.
    always_comb begin
        ret_d    = ret_q + 16'(pop);
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            occ_d    = '0;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            occ_d    = occ_q + OW'(acc) - OW'(pop);
            cnt_d    = cnt_q + OW'(q_wr_vld) - OW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(q_wr_vld);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_q     <= 1'b0;
            occ_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ret_q    <= '0;
        end else begin
            up_q     <= 1'b1;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ret_q    <= ret_d;
        end
    end

endmodule
